// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register: captures fetch output, supports stall/flush,
// and presents decode with pre-split fields, SignImm and branch/jump targets.
// Ports: clk, reset (sync, active-high), stall_D, flush_D, instr_F,
// PCPlus4_F in; instr_D, PCPlus4_D, valid_D, field, SignImm and target outputs.
// Optional macro FETCH_DECODE_PERF_EN adds saturating stall_cnt_D/flush_cnt_D.
module fetch_decode_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic [31:0] instr_F,
  input  logic [31:0] PCPlus4_F,
  output logic [31:0] instr_D,
  output logic [31:0] PCPlus4_D,
  output logic        valid_D,
  output logic [5:0]  opcode_D,
  output logic [4:0]  rs_D,
  output logic [4:0]  rt_D,
  output logic [4:0]  rd_D,
  output logic [4:0]  shamt_D,
  output logic [5:0]  funct_D,
  output logic [31:0] SignImm_D,
  output logic [31:0] PCBranch_D,
  output logic [31:0] PCJump_D
`ifdef FETCH_DECODE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_D,
  output logic [CNT_W-1:0] flush_cnt_D
`endif
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  // Stall outranks flush; a flush under stall is dropped, not deferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (stall_D) begin
      instr_q <= instr_q;
      pc4_q   <= pc4_q;
      valid_q <= valid_q;
    end else if (flush_D) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_F;
      pc4_q   <= PCPlus4_F;
      valid_q <= 1'b1;
    end
  end

  assign instr_D   = instr_q;
  assign PCPlus4_D = pc4_q;
  assign valid_D   = valid_q;
  assign opcode_D  = instr_q[31:26];
  assign rs_D      = instr_q[25:21];
  assign rt_D      = instr_q[20:16];
  assign rd_D      = instr_q[15:11];
  assign shamt_D   = instr_q[10:6];
  assign funct_D   = instr_q[5:0];
  assign SignImm_D = {{16{instr_q[15]}}, instr_q[15:0]};

  // Word offset: SignImm<<2 drops bits 31:30; carry out is discarded.
  assign PCBranch_D = {SignImm_D[29:0], 2'b00} + pc4_q;
  assign PCJump_D   = {pc4_q[31:28], instr_q[25:0], 2'b00};

`ifdef FETCH_DECODE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_D <= '0;
      flush_cnt_D <= '0;
    end else begin
      if (stall_D && stall_cnt_D != CNT_MAX)
        stall_cnt_D <= stall_cnt_D + CNT_ONE;
      if (flush_D && !stall_D && flush_cnt_D != CNT_MAX)
        flush_cnt_D <= flush_cnt_D + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Self-checking bench for fetch_decode_reg: directed table, hand-written
// stall/flush/reset sequences, and randomized traffic against a model.
module tb_fetch_decode_reg;

`ifdef FETCH_DECODE_PERF_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        reset, stall_D, flush_D;
  logic [31:0] instr_F, PCPlus4_F;
  logic [31:0] instr_D, PCPlus4_D;
  logic        valid_D;
  logic [5:0]  opcode_D, funct_D;
  logic [4:0]  rs_D, rt_D, rd_D, shamt_D;
  logic [31:0] SignImm_D, PCBranch_D, PCJump_D;
`ifdef FETCH_DECODE_PERF_EN
  logic [CW-1:0] stall_cnt_D, flush_cnt_D;
`endif

  fetch_decode_reg #(.NOP_INSTR(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall_D(stall_D), .flush_D(flush_D),
    .instr_F(instr_F), .PCPlus4_F(PCPlus4_F),
    .instr_D(instr_D), .PCPlus4_D(PCPlus4_D), .valid_D(valid_D),
    .opcode_D(opcode_D), .rs_D(rs_D), .rt_D(rt_D), .rd_D(rd_D),
    .shamt_D(shamt_D), .funct_D(funct_D), .SignImm_D(SignImm_D),
    .PCBranch_D(PCBranch_D), .PCJump_D(PCJump_D)
`ifdef FETCH_DECODE_PERF_EN
    ,
    .stall_cnt_D(stall_cnt_D), .flush_cnt_D(flush_cnt_D)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model state
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  int          m_scnt, m_fcnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, s, f,
                            input logic [31:0] i, p);
    if (r) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
    end else if (s) begin
      if (m_scnt < CMAX) m_scnt++;
    end else if (f) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      if (m_fcnt < CMAX) m_fcnt++;
    end else begin
      m_instr = i; m_pc4 = p; m_valid = 1;
    end
  endtask

  task automatic cmp_model();
    int im;
    logic [31:0] simm, br, jmp;
    im = int'(m_instr & 32'hFFFF);
    if (im >= 32768) im = im - 65536;
    simm = 32'(im);
    br   = m_pc4 + 32'(im * 4);
    jmp  = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
    chk("instr", instr_D, m_instr);
    chk("pc4", PCPlus4_D, m_pc4);
    chk("valid", {31'b0, valid_D}, {31'b0, m_valid});
    chk("opcode", {26'b0, opcode_D}, m_instr >> 26);
    chk("rs", {27'b0, rs_D}, (m_instr >> 21) & 32'h1F);
    chk("rt", {27'b0, rt_D}, (m_instr >> 16) & 32'h1F);
    chk("rd", {27'b0, rd_D}, (m_instr >> 11) & 32'h1F);
    chk("shamt", {27'b0, shamt_D}, (m_instr >> 6) & 32'h1F);
    chk("funct", {26'b0, funct_D}, m_instr & 32'h3F);
    chk("simm", SignImm_D, simm);
    chk("branch", PCBranch_D, br);
    chk("jump", PCJump_D, jmp);
`ifdef FETCH_DECODE_PERF_EN
    chk("stall_cnt", 32'(stall_cnt_D), 32'(m_scnt));
    chk("flush_cnt", 32'(flush_cnt_D), 32'(m_fcnt));
`endif
  endtask

  task automatic step(input logic r, s, f, input logic [31:0] i, p);
    reset = r; stall_D = s; flush_D = f; instr_F = i; PCPlus4_F = p;
    model_edge(r, s, f, i, p);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic r, s, f;
    logic [31:0] i, p;
    logic [31:0] e_instr, e_pc4;
    logic e_valid;
    logic [31:0] e_simm, e_br, e_jmp;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; stall_D = 0; flush_D = 0; instr_F = 0; PCPlus4_F = 0;
    m_instr = 0; m_pc4 = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;

    tbl[0] = '{1, 0, 0, 32'h1234_5678, 32'h4, 32'h0, 32'h0, 0,
               32'h0, 32'h0, 32'h0};
    tbl[1] = '{0, 0, 0, 32'h8C48_0004, 32'h8, 32'h8C48_0004, 32'h8, 1,
               32'h4, 32'h18, 32'h0120_0010};
    tbl[2] = '{0, 0, 0, 32'h1000_FFFF, 32'h10, 32'h1000_FFFF, 32'h10, 1,
               32'hFFFF_FFFF, 32'hC, 32'h0003_FFFC};
    tbl[3] = '{0, 0, 0, 32'h1000_FFFF, 32'h0, 32'h1000_FFFF, 32'h0, 1,
               32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0003_FFFC};
    tbl[4] = '{0, 0, 0, 32'h0800_0040, 32'hA000_0004, 32'h0800_0040,
               32'hA000_0004, 1, 32'h40, 32'hA000_0104, 32'hA000_0100};
    tbl[5] = '{0, 0, 1, 32'h2222_2222, 32'h44, 32'h0, 32'h0, 0,
               32'h0, 32'h0, 32'h0};
    tbl[6] = '{0, 0, 0, 32'h2010_0005, 32'h20, 32'h2010_0005, 32'h20, 1,
               32'h5, 32'h34, 32'h0040_0014};

    @(posedge clk);
    #1;
    for (int k = 0; k < 7; k++) begin
      step(tbl[k].r, tbl[k].s, tbl[k].f, tbl[k].i, tbl[k].p);
      chk($sformatf("tbl%0d_instr", k), instr_D, tbl[k].e_instr);
      chk($sformatf("tbl%0d_pc4", k), PCPlus4_D, tbl[k].e_pc4);
      chk($sformatf("tbl%0d_valid", k), {31'b0, valid_D},
          {31'b0, tbl[k].e_valid});
      chk($sformatf("tbl%0d_simm", k), SignImm_D, tbl[k].e_simm);
      chk($sformatf("tbl%0d_br", k), PCBranch_D, tbl[k].e_br);
      chk($sformatf("tbl%0d_jmp", k), PCJump_D, tbl[k].e_jmp);
    end
    chk("tbl1_opcode_chk", 32'h23, 32'h23 & 32'h3F);

    // Stall: hold A for 3 cycles while instr_F changes, then load E.
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'hAAAA_0001, 32'h100);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 32'hB000_0000 + 32'(k), 32'h200 + 32'(k));
      chk("stall_hold", instr_D, 32'hAAAA_0001);
    end
`ifdef FETCH_DECODE_PERF_EN
    chk("stall_cnt3", 32'(stall_cnt_D), 32'd3);
`endif
    step(0, 0, 0, 32'hEEEE_0002, 32'h300);
    chk("stall_resume", instr_D, 32'hEEEE_0002);

    // Stall and flush together: hold, flush dropped.
    step(0, 1, 1, 32'hDEAD_BEEF, 32'h400);
    chk("stflush_hold", instr_D, 32'hEEEE_0002);
    chk("stflush_valid", {31'b0, valid_D}, 32'd1);
`ifdef FETCH_DECODE_PERF_EN
    chk("stflush_fcnt", 32'(flush_cnt_D), 32'd0);
`endif
    step(0, 0, 0, 32'h0BAD_F00D, 32'h404);
    chk("flush_not_kept", instr_D, 32'h0BAD_F00D);

    // Flush: one bubble, then the next instruction loads.
    step(0, 0, 1, 32'h1111_1111, 32'h500);
    chk("flush_bubble", {instr_D[31:1], valid_D}, 32'h0);
    step(0, 0, 0, 32'h2222_3333, 32'h504);
    chk("flush_next", instr_D, 32'h2222_3333);

    // Reset mid-stall takes effect on that edge.
    step(0, 1, 0, 32'h5555_5555, 32'h600);
    step(1, 1, 1, 32'h6666_6666, 32'h604);
    chk("rst_midstall", instr_D, 32'h0);
    step(0, 0, 0, 32'h7777_7777, 32'h608);
    chk("post_rst_load", instr_D, 32'h7777_7777);

`ifdef FETCH_DECODE_PERF_EN
    for (int k = 0; k < 20; k++) step(0, 1, 0, 32'(k), 32'h0);
    chk("stall_sat", 32'(stall_cnt_D), 32'd15);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 32'(k), 32'h0);
    chk("flush_sat", 32'(flush_cnt_D), 32'd15);
    step(1, 0, 0, 32'h0, 32'h0);
    chk("sat_rst_s", 32'(stall_cnt_D), 32'd0);
    chk("sat_rst_f", 32'(flush_cnt_D), 32'd0);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
